// File: rtl/traffic_phase_fsm.sv
// Two-road (A/B) signal phase controller.
// Owns the phase register sampled by the external stop counter, consumes that
// counter's Traffic_stop value to hand green to a waiting road, inserts yellow
// and all-red clearance, and flashes yellow on both roads while Fault is high.
//
// Handshake note: there is no valid/ready traffic here. Demand inputs are plain
// levels sampled every rising edge; Traffic_stop is a registered value that the
// stop counter derives from `state`, so it lags the phase by one cycle.
module traffic_phase_fsm #(
    parameter int STOP_THRESHOLD = 10,
    parameter int MIN_GREEN      = 20,
    parameter int YELLOW_TIME    = 4,
    parameter int ALL_RED_TIME   = 3,
    parameter int BLINK_HALF     = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Fault,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    input  logic [9:0] Traffic_stop,
    output logic [2:0] state,
    output logic [2:0] A_light,
    output logic [2:0] B_light
);

    // Phase encoding is fixed: the stop counter decodes these values.
    localparam logic [2:0] INIT_STATE  = 3'd0;
    localparam logic [2:0] A_STATE     = 3'd1;  // B green, A waiting
    localparam logic [2:0] B_STATE     = 3'd2;  // A green, B waiting
    localparam logic [2:0] A_IS_GREEN  = 3'd3;
    localparam logic [2:0] B_IS_GREEN  = 3'd4;
    localparam logic [2:0] BLINK_STATE = 3'd5;
    localparam logic [2:0] A_YELLOW    = 3'd6;
    localparam logic [2:0] B_YELLOW    = 3'd7;

    // Light patterns, {R,Y,G}.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    // Timer compare points, pre-sized to the 10-bit timer.
    localparam logic [9:0] TIMER_MAX      = 10'h3FF;
    localparam logic [9:0] STOP_THR       = 10'(STOP_THRESHOLD);
    localparam logic [9:0] MIN_GREEN_LAST = 10'(MIN_GREEN - 1);
    localparam logic [9:0] YELLOW_LAST    = 10'(YELLOW_TIME - 1);
    localparam logic [9:0] ALL_RED_LAST   = 10'(ALL_RED_TIME - 1);
    localparam logic [9:0] BLINK_LAST     = 10'(BLINK_HALF - 1);

    logic [2:0] state_q, state_d;
    logic [9:0] timer_q, timer_d;
    logic       blink_tog_q, blink_tog_d;
    logic       timer_clr;

    // Next-phase selection; Fault overrides every other condition.
    always_comb begin
        state_d = state_q;
        if (Fault) begin
            state_d = BLINK_STATE;
        end else begin
            case (state_q)
                INIT_STATE: begin
                    if (timer_q == ALL_RED_LAST) state_d = A_IS_GREEN;
                end
                A_IS_GREEN: begin
                    if (B_Traffic && (timer_q >= MIN_GREEN_LAST)) state_d = B_STATE;
                end
                B_STATE: begin
                    // Threshold wins over a dropped request in the same cycle.
                    if (Traffic_stop >= STOP_THR) state_d = A_YELLOW;
                    else if (!B_Traffic)          state_d = A_IS_GREEN;
                end
                A_YELLOW: begin
                    if (timer_q == YELLOW_LAST) state_d = B_IS_GREEN;
                end
                B_IS_GREEN: begin
                    if (A_Traffic && (timer_q >= MIN_GREEN_LAST)) state_d = A_STATE;
                end
                A_STATE: begin
                    if (Traffic_stop >= STOP_THR) state_d = B_YELLOW;
                    else if (!A_Traffic)          state_d = B_IS_GREEN;
                end
                B_YELLOW: begin
                    if (timer_q == YELLOW_LAST) state_d = A_IS_GREEN;
                end
                BLINK_STATE: begin
                    state_d = INIT_STATE;
                end
                default: begin
                    state_d = INIT_STATE;
                end
            endcase
        end
    end

    // Timer and flash toggle. Green time keeps accumulating across the
    // green<->waiting moves so a repeated request is not re-delayed.
    always_comb begin
        timer_clr   = 1'b0;
        blink_tog_d = blink_tog_q;
        if (state_d != state_q) begin
            case (state_d)
                INIT_STATE, A_YELLOW, B_YELLOW: timer_clr = 1'b1;
                BLINK_STATE: begin
                    timer_clr   = 1'b1;
                    blink_tog_d = 1'b0;
                end
                A_IS_GREEN: timer_clr = (state_q == B_YELLOW) || (state_q == INIT_STATE);
                B_IS_GREEN: timer_clr = (state_q == A_YELLOW);
                default:    timer_clr = 1'b0;
            endcase
        end else if ((state_q == BLINK_STATE) && (timer_q == BLINK_LAST)) begin
            timer_clr   = 1'b1;
            blink_tog_d = ~blink_tog_q;
        end

        if (timer_clr)                  timer_d = '0;
        else if (timer_q == TIMER_MAX)  timer_d = timer_q;
        else                            timer_d = timer_q + 10'd1;
    end

    // Phase, timer and flash registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= INIT_STATE;
            timer_q     <= '0;
            blink_tog_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_tog_q <= blink_tog_d;
        end
    end

    // Lights are a pure decode of the phase so they change with `state`.
    always_comb begin
        A_light = LIGHT_RED;
        B_light = LIGHT_RED;
        case (state_q)
            A_IS_GREEN, B_STATE: A_light = LIGHT_GREEN;
            B_IS_GREEN, A_STATE: B_light = LIGHT_GREEN;
            A_YELLOW:            A_light = LIGHT_YELLOW;
            B_YELLOW:            B_light = LIGHT_YELLOW;
            BLINK_STATE: begin
                A_light = blink_tog_q ? LIGHT_YELLOW : LIGHT_OFF;
                B_light = blink_tog_q ? LIGHT_YELLOW : LIGHT_OFF;
            end
            default: begin
                A_light = LIGHT_RED;
                B_light = LIGHT_RED;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
Two-road (A/B) signal phase controller. It owns the 3-bit `state` register that the high-traffic stop counter samples, and it consumes that counter's 10-bit `Traffic_stop` output to decide when a waiting road gets green. It drives red/yellow/green for both roads, inserts yellow and all-red clearance, and enters a blinking fault mode on demand.

Parameters:
STOP_THRESHOLD, 10, Traffic_stop value (>=) that grants green to the waiting road
MIN_GREEN, 20, minimum cycles a road stays green before the other road's demand is accepted
YELLOW_TIME, 4, cycles of yellow on the road losing green
ALL_RED_TIME, 3, cycles of all-red in init_state after reset or fault clear
BLINK_HALF, 8, half-period in cycles of the fault-mode yellow flash

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-low reset
Fault  in  1  level; 1 forces blink mode
A_Traffic  in  1  vehicle demand on road A
B_Traffic  in  1  vehicle demand on road B
Traffic_stop  in  10  registered stop counter fed back from the stop-counter stage
state  out  3  current phase, registered
A_light  out  3  {R,Y,G} road A, one-hot or 000
B_light  out  3  {R,Y,G} road B, one-hot or 000

Behaviour:
- Encoding: init_state=0, A_state=1, B_state=2, A_is_green=3, B_is_green=4, Blink_state=5, A_yellow=6, B_yellow=7.
- Reset low, asynchronous: state=0, timer=0, blink_tog=0, A_light=B_light=100. All outputs hold these values until the first rising edge after release.
- timer: 10-bit, saturates at 1023, increments every cycle. Cleared on entry to init_state, A_yellow, B_yellow, Blink_state, and on entry to A_is_green from B_yellow or init_state, and to B_is_green from A_yellow. Not cleared on A_is_green<->B_state or B_is_green<->A_state moves, so green time accumulates across them.
- Priority in every state: Fault=1 -> Blink_state on the next edge. This overrides everything below.
- init_state: both red. At timer==ALL_RED_TIME-1 -> A_is_green. init_state lasts exactly ALL_RED_TIME cycles.
- A_is_green: A green, B red. If B_Traffic=1 and timer>=MIN_GREEN-1 -> B_state. A_Traffic is ignored.
- B_state: A green, B red. B is waiting, and the stop counter accumulates.
  - If Traffic_stop>=STOP_THRESHOLD -> A_yellow.
  - Else if B_Traffic=0 -> A_is_green.
  - Threshold wins when both hold in the same cycle.
- A_yellow: A yellow, B red. At timer==YELLOW_TIME-1 -> B_is_green.
- B_is_green, A_state, B_yellow: mirror images of the three states above with A and B swapped.
- Stop-counter timing: Traffic_stop reads 0 in the first cycle of X_state and reaches N after N cycles there. With constant demand, X_state therefore lasts STOP_THRESHOLD+1 cycles.
- Blink_state:
  - Both lights show 010 when blink_tog=1 and 000 when blink_tog=0.
  - blink_tog is cleared on entry and toggles when timer reaches BLINK_HALF-1; timer clears at each toggle.
  - Fault=0 -> init_state.
- Lights are a pure decode of the state register (and blink_tog), with no extra latency: light changes in the same cycle as `state`.
- Outside Blink_state the lights are never all-off, and at most one road is non-red.

Test Plan:
- Common setup: STOP_THRESHOLD=4, MIN_GREEN=3, YELLOW_TIME=2, ALL_RED_TIME=2, BLINK_HALF=2, with a stop-counter model in the loop.
- Reset release, no traffic -> state=0 for 2 cycles, then 3; A_light=001, B_light=100 held indefinitely.
- Async reset asserted mid-cycle while in state 6 -> state=0 and both lights 100 immediately, before the next edge.
- In state 3 with timer>=2, B_Traffic held 1 -> state=2 for 5 cycles (Traffic_stop 0..4), then 6 for 2 cycles with A_light=010, then 4 with B_light=001.
- In state 3, B_Traffic=1 for 2 cycles then 0 -> state 3->2->2->3, no yellow; a later request goes straight to 2 because timer was not cleared.
- Fault=1 in state 2 -> next state 5; both lights 000,000,010,010,000 repeating with period 4; Fault=0 -> state 0 for 2 cycles, then 3.
- B_Traffic rises in state 3 at timer=0 -> no transition until timer reaches 2, then state 2.
